abnormality_alarm_scheduler: RTL and testbench
==============================================

ABNORMALITY_ALARM_SCHEDULER -- requirements
Module: abnormality_alarm_scheduler

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16: cycles allowed for alarmAck before escalation, range 2..255.
REQ-002 Parameter COOLDOWN_CYCLES, default 4: idle gap after each acknowledged alarm, range 1..255.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 abnormalityVector  input  6  {presure, blood, fall, temperature, nervous[1], nervous[0]}, level signals from detectors.
REQ-006 enableMask  input  6  per-bit event enable, same bit order as abnormalityVector; 0 ignores that source.
REQ-007 alarmAck  input  1  one-cycle acknowledge from the operator or host for the current alarm.
REQ-008 alarmValid  output  1  high while an alarm is presented and awaiting acknowledge.
REQ-009 abnormalityWarning  output  3  code of the presented alarm; 0 = none.
REQ-010 pendingVector  output  6  latched, unserved events.
REQ-011 escalate  output  1  one-cycle pulse on acknowledge timeout.
REQ-012 escalateCount  output  4  saturating count of escalations since reset.

Function
REQ-013 Each enabled input bit's 0->1 transition, relative to its registered previous value, shall set the corresponding pendingVector bit one cycle later; a level held high shall not re-set the bit.
REQ-014 Fixed priority and codes: fall=1, presure=2, nervous[1]=3, blood=4, temperature=5, nervous[0]=6; highest is fall.
REQ-015 FSM states: IDLE, ALERT, COOLDOWN.
REQ-016 IDLE: when pendingVector is nonzero, select the highest-priority pending bit, register its code, and enter ALERT next cycle; alarmValid=0 and abnormalityWarning=0 while in IDLE.
REQ-017 ALERT: alarmValid=1; abnormalityWarning holds the selected code; no preemption by higher-priority events.
REQ-018 ALERT with alarmAck=1: clear the served pending bit, enter COOLDOWN, and load the cooldown counter.
REQ-019 ALERT without ack: the timeout counter increments; when ACK_TIMEOUT cycles elapse, pulse escalate for one cycle, increment escalateCount (saturating at 15), restart the counter, and remain in ALERT with the same code.
REQ-020 alarmAck in the same cycle as timeout expiry: the ack wins; no escalate pulse and no count change.
REQ-021 A new rising edge on the served bit in the same cycle as its ack: the set wins, the bit stays pending, and no event is lost.
REQ-022 alarmAck outside ALERT shall be ignored.
REQ-023 COOLDOWN: alarmValid=0, abnormalityWarning=0 for exactly COOLDOWN_CYCLES cycles, then IDLE; events continue to latch during COOLDOWN.
REQ-024 Clearing an enableMask bit shall clear that pending bit next cycle; if that bit is being served, the alarm stays in ALERT until ack or timeout.
REQ-025 All outputs shall be registered; event edge to alarmValid latency from IDLE with nothing pending is 3 cycles: edge register, pending, ALERT.

Reset
REQ-026 resetN low shall asynchronously force: state IDLE, pendingVector 0, previous-input register 0, counters 0, alarmValid 0, abnormalityWarning 0, escalate 0, escalateCount 0.
REQ-027 Reset asserted mid-ALERT or mid-COOLDOWN shall abandon the alarm; no escalate pulse shall occur on reset.
REQ-028 After reset release, inputs already high shall register as rising edges.

Structure
REQ-029 A shared package shall hold the FSM state encoding, the six warning code constants, and the bit-index constants of the abnormality vector.
REQ-030 One sub-module, abnormality_priority_encoder, shall map the 6-bit pending vector to a 3-bit code and a one-hot grant; it shall be purely combinational.

Verification
REQ-031 Single event: fall rises at cycle 0, mask all ones -> alarmValid=1, warning=1 at cycle 3; ack -> 4 cycles of 0, then IDLE.
REQ-032 Simultaneous: temperature and presure rise together -> warning=2 first; after ack and cooldown, warning=5.
REQ-033 Timeout: ALERT with no ack, ACK_TIMEOUT=16 -> escalate pulses at cycles 16 and 32 of ALERT, escalateCount=2, code unchanged; 20 timeouts -> count saturates at 15.
REQ-034 Ack coincides with timeout expiry -> no escalate pulse, COOLDOWN entered.
REQ-035 Masking: enableMask[bit of blood]=0 and blood rises -> pendingVector stays 0 and no alarm.
REQ-036 resetN pulled low during ALERT with code 3 -> all outputs 0 immediately; after release, a held nervous[1] re-alarms with code 3.

Source files
------------

// File: rtl/abnormality_alarm_scheduler_pkg.sv
// Shared definitions for the abnormality alarm scheduler: FSM encoding,
// warning codes and bit positions inside the abnormality vector.
package abnormality_alarm_scheduler_pkg;

  localparam int VEC_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALERT    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  // Bit positions of {presure, blood, fall, temperature, nervous[1], nervous[0]}
  localparam int BIT_NERVOUS0    = 0;
  localparam int BIT_NERVOUS1    = 1;
  localparam int BIT_TEMPERATURE = 2;
  localparam int BIT_FALL        = 3;
  localparam int BIT_BLOOD       = 4;
  localparam int BIT_PRESURE     = 5;

  localparam logic [2:0] CODE_NONE        = 3'd0;
  localparam logic [2:0] CODE_FALL        = 3'd1;
  localparam logic [2:0] CODE_PRESURE     = 3'd2;
  localparam logic [2:0] CODE_NERVOUS1    = 3'd3;
  localparam logic [2:0] CODE_BLOOD       = 3'd4;
  localparam logic [2:0] CODE_TEMPERATURE = 3'd5;
  localparam logic [2:0] CODE_NERVOUS0    = 3'd6;

endpackage

// File: rtl/abnormality_alarm_scheduler_if.sv
// Detector/operator side bundle of the alarm scheduler; master drives the
// detector levels, mask and acknowledge, slave is the scheduler.
interface abnormality_alarm_scheduler_if;
  import abnormality_alarm_scheduler_pkg::*;

  logic [VEC_W-1:0] abnormalityVector;
  logic [VEC_W-1:0] enableMask;
  logic             alarmAck;
  logic             alarmValid;
  logic [2:0]       abnormalityWarning;
  logic [VEC_W-1:0] pendingVector;
  logic             escalate;
  logic [3:0]       escalateCount;

  modport master (
    output abnormalityVector, enableMask, alarmAck,
    input  alarmValid, abnormalityWarning, pendingVector, escalate, escalateCount
  );

  modport slave (
    input  abnormalityVector, enableMask, alarmAck,
    output alarmValid, abnormalityWarning, pendingVector, escalate, escalateCount
  );

endinterface

// File: rtl/abnormality_priority_encoder.sv
// Combinational fixed-priority selection of the most urgent pending event:
// fall > presure > nervous[1] > blood > temperature > nervous[0].
module abnormality_priority_encoder
  import abnormality_alarm_scheduler_pkg::*;
(
  input  logic [VEC_W-1:0] pending,
  output logic [2:0]       code,
  output logic [VEC_W-1:0] grant
);

  always_comb begin
    code  = CODE_NONE;
    grant = '0;
    if (pending[BIT_FALL]) begin
      code            = CODE_FALL;
      grant[BIT_FALL] = 1'b1;
    end else if (pending[BIT_PRESURE]) begin
      code               = CODE_PRESURE;
      grant[BIT_PRESURE] = 1'b1;
    end else if (pending[BIT_NERVOUS1]) begin
      code                = CODE_NERVOUS1;
      grant[BIT_NERVOUS1] = 1'b1;
    end else if (pending[BIT_BLOOD]) begin
      code             = CODE_BLOOD;
      grant[BIT_BLOOD] = 1'b1;
    end else if (pending[BIT_TEMPERATURE]) begin
      code                   = CODE_TEMPERATURE;
      grant[BIT_TEMPERATURE] = 1'b1;
    end else if (pending[BIT_NERVOUS0]) begin
      code                = CODE_NERVOUS0;
      grant[BIT_NERVOUS0] = 1'b1;
    end
  end

endmodule

// File: rtl/abnormality_alarm_scheduler.sv
// Latches rising detector events, presents them one at a time by priority,
// escalates on missing acknowledge and enforces a cooldown gap after each ack.
module abnormality_alarm_scheduler
  import abnormality_alarm_scheduler_pkg::*;
#(
  parameter int ACK_TIMEOUT     = 16,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic                           clock,
  input  logic                           resetN,
  abnormality_alarm_scheduler_if.slave   bus
);

  localparam logic [7:0] TIMEOUT_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] COOLDOWN_LAST = 8'(COOLDOWN_CYCLES - 1);

  state_t           state;
  logic [VEC_W-1:0] prev_vec;
  logic [VEC_W-1:0] rise_p0;
  logic [VEC_W-1:0] pending;
  logic [VEC_W-1:0] served;
  logic [VEC_W-1:0] ack_clear;
  logic [VEC_W-1:0] enc_grant;
  logic [2:0]       enc_code;
  logic [7:0]       ack_timer;
  logic [7:0]       cool_timer;
  logic             alarm_valid;
  logic [2:0]       warning;
  logic             escalate_pulse;
  logic [3:0]       escalate_count;

  abnormality_priority_encoder u_encoder (
    .pending (pending),
    .code    (enc_code),
    .grant   (enc_grant)
  );

  // Ack is only meaningful while an alarm is presented
  assign ack_clear = (state == ST_ALERT && bus.alarmAck) ? served : '0;

  // Stage p0: edge register against the previous detector levels
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      prev_vec <= '0;
      rise_p0  <= '0;
    end else begin
      prev_vec <= bus.abnormalityVector;
      rise_p0  <= bus.abnormalityVector & ~prev_vec;
    end
  end

  // Stage p1: pending latch; a fresh rise beats the ack clear, mask drops bits
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~ack_clear) | rise_p0) & bus.enableMask;
    end
  end

  // Stage p2: alarm presentation FSM with registered outputs
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state          <= ST_IDLE;
      served         <= '0;
      ack_timer      <= '0;
      cool_timer     <= '0;
      alarm_valid    <= 1'b0;
      warning        <= CODE_NONE;
      escalate_pulse <= 1'b0;
      escalate_count <= '0;
    end else begin
      escalate_pulse <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|pending) begin
            state       <= ST_ALERT;
            served      <= enc_grant;
            warning     <= enc_code;
            alarm_valid <= 1'b1;
            ack_timer   <= '0;
          end
        end
        ST_ALERT: begin
          if (bus.alarmAck) begin
            state       <= ST_COOLDOWN;
            alarm_valid <= 1'b0;
            warning     <= CODE_NONE;
            cool_timer  <= COOLDOWN_LAST;
          end else if (ack_timer == TIMEOUT_LAST) begin
            escalate_pulse <= 1'b1;
            ack_timer      <= '0;
            if (escalate_count != 4'hF) escalate_count <= escalate_count + 4'd1;
          end else begin
            ack_timer <= ack_timer + 8'd1;
          end
        end
        ST_COOLDOWN: begin
          if (cool_timer == 8'd0) state <= ST_IDLE;
          else cool_timer <= cool_timer - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.alarmValid         = alarm_valid;
  assign bus.abnormalityWarning = warning;
  assign bus.pendingVector      = pending;
  assign bus.escalate           = escalate_pulse;
  assign bus.escalateCount      = escalate_count;

endmodule

// File: tb/tb_abnormality_alarm_scheduler.sv
// Randomized and directed bench for abnormality_alarm_scheduler against a
// cycle-level behavioural model of latching, priority, timeout and cooldown.
module tb_abnormality_alarm_scheduler;

  localparam int ACK_TIMEOUT     = 16;
  localparam int COOLDOWN_CYCLES = 4;

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  abnormality_alarm_scheduler_if bus ();

  abnormality_alarm_scheduler #(
    .ACK_TIMEOUT     (ACK_TIMEOUT),
    .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: priority order as bit indices, code = position + 1
  int prio_bit [6] = '{3, 5, 1, 4, 2, 0};
  logic [5:0] m_prev, m_rise, m_pend;
  int m_phase;   // 0 idle, 1 alert, 2 cooldown
  int m_code, m_bit, m_age, m_cool, m_esc, m_cnt;

  task automatic model_reset();
    m_prev = '0; m_rise = '0; m_pend = '0;
    m_phase = 0; m_code = 0; m_bit = 0; m_age = 0; m_cool = 0; m_esc = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [5:0] v, input logic [5:0] mask, input logic ack);
    logic [5:0] clr;
    bit found;
    clr   = '0;
    found = 0;
    m_esc = 0;
    if (m_phase == 0) begin
      for (int i = 0; i < 6; i++) begin
        if (!found && m_pend[prio_bit[i]]) begin
          found   = 1;
          m_phase = 1;
          m_code  = i + 1;
          m_bit   = prio_bit[i];
          m_age   = 0;
        end
      end
    end else if (m_phase == 1) begin
      if (ack) begin
        clr[m_bit] = 1'b1;
        m_phase    = 2;
        m_cool     = COOLDOWN_CYCLES;
      end else begin
        m_age++;
        if (m_age == ACK_TIMEOUT) begin
          m_esc = 1;
          m_age = 0;
          if (m_cnt < 15) m_cnt++;
        end
      end
    end else begin
      m_cool--;
      if (m_cool == 0) m_phase = 0;
    end
    m_pend = ((m_pend & ~clr) | m_rise) & mask;
    m_rise = v & ~m_prev;
    m_prev = v;
  endtask

  task automatic check_outputs();
    check("valid",   32'(bus.alarmValid),         (m_phase == 1) ? 1 : 0);
    check("warning", 32'(bus.abnormalityWarning), (m_phase == 1) ? m_code : 0);
    check("pending", 32'(bus.pendingVector),      32'(m_pend));
    check("escal",   32'(bus.escalate),           m_esc);
    check("esc_cnt", 32'(bus.escalateCount),      m_cnt);
  endtask

  task automatic tick();
    @(posedge clock);
    if (resetN) model_step(bus.abnormalityVector, bus.enableMask, bus.alarmAck);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ack_now();
    bus.alarmAck = 1'b1;
    tick();
    bus.alarmAck = 1'b0;
  endtask

  task automatic random_run(input int cycles, input int ack_div);
    for (int i = 0; i < cycles; i++) begin
      int b;
      b = int'($urandom_range(5));
      if ($urandom_range(5) == 0) bus.abnormalityVector[b] = ~bus.abnormalityVector[b];
      if ($urandom_range(39) == 0) bus.enableMask[b] = ~bus.enableMask[b];
      if ($urandom_range(7) == 0) bus.enableMask = 6'h3F;
      bus.alarmAck = ($urandom_range(ack_div - 1) == 0);
      tick();
    end
    bus.alarmAck = 1'b0;
  endtask

  initial begin
    bus.abnormalityVector = '0;
    bus.enableMask        = 6'h3F;
    bus.alarmAck          = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs();
    resetN = 1'b1;

    // Single fall event: 3-cycle latency, ack, cooldown
    bus.abnormalityVector[3] = 1'b1;
    ticks(2);
    check("lat_not_yet", 32'(bus.alarmValid), 0);
    tick();
    check("lat_valid", 32'(bus.alarmValid), 1);
    check("lat_code",  32'(bus.abnormalityWarning), 1);
    bus.abnormalityVector = '0;
    ack_now();
    ticks(COOLDOWN_CYCLES + 2);

    // Simultaneous temperature and presure
    bus.abnormalityVector = 6'b100100;
    ticks(3);
    check("simul_first", 32'(bus.abnormalityWarning), 2);
    ack_now();
    ticks(COOLDOWN_CYCLES + 1);
    check("simul_second", 32'(bus.abnormalityWarning), 5);
    ack_now();
    bus.abnormalityVector = '0;
    ticks(COOLDOWN_CYCLES + 2);

    // Timeouts on nervous[1] and saturation of the escalate count
    bus.abnormalityVector[1] = 1'b1;
    ticks(3);
    ticks(2 * ACK_TIMEOUT);
    check("to_pulse2", 32'(bus.escalate), 1);
    check("to_cnt2",   32'(bus.escalateCount), 2);
    check("to_code",   32'(bus.abnormalityWarning), 3);
    ticks(18 * ACK_TIMEOUT);
    check("to_sat", 32'(bus.escalateCount), 15);

    // Asynchronous reset mid-ALERT with code 3
    #2 resetN = 1'b0;
    #1;
    check("rst_valid",   32'(bus.alarmValid), 0);
    check("rst_warning", 32'(bus.abnormalityWarning), 0);
    check("rst_pending", 32'(bus.pendingVector), 0);
    check("rst_escal",   32'(bus.escalate), 0);
    check("rst_cnt",     32'(bus.escalateCount), 0);
    model_reset();
    @(negedge clock);
    resetN = 1'b1;
    ticks(3);
    check("rerun_valid", 32'(bus.alarmValid), 1);
    check("rerun_code",  32'(bus.abnormalityWarning), 3);

    // Ack coinciding with timeout expiry
    for (int i = 0; i < 4 * ACK_TIMEOUT && m_age != ACK_TIMEOUT - 1; i++) tick();
    check("coinc_age", m_age, ACK_TIMEOUT - 1);
    bus.abnormalityVector = '0;
    ack_now();
    check("coinc_escal", 32'(bus.escalate), 0);
    check("coinc_cnt",   32'(bus.escalateCount), 0);
    check("coinc_valid", 32'(bus.alarmValid), 0);
    ticks(COOLDOWN_CYCLES + 2);

    // Masked blood never latches
    bus.enableMask[4] = 1'b0;
    bus.abnormalityVector[4] = 1'b1;
    ticks(4);
    check("mask_pend",  32'(bus.pendingVector), 0);
    check("mask_valid", 32'(bus.alarmValid), 0);
    bus.enableMask = 6'h3F;
    bus.abnormalityVector = '0;
    ticks(2);

    // Re-rise of the served bit in the ack cycle keeps it pending
    bus.abnormalityVector[3] = 1'b1;
    ticks(3);
    bus.abnormalityVector[3] = 1'b0;
    tick();
    bus.abnormalityVector[3] = 1'b1;
    tick();
    ack_now();
    check("reedge_pend", 32'(bus.pendingVector[3]), 1);
    ticks(COOLDOWN_CYCLES + 2);
    check("reedge_code", 32'(bus.abnormalityWarning), 1);

    random_run(800, 10);
    random_run(700, 40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
